// File: rtl/cache_types.sv
// Shared cache controller types: FSM state encoding and default tuning constants.
// The cache datapath imports this package to decode the controller's state output.
package cache_types;

    typedef enum logic [2:0] {
        idle_s        = 3'd0,
        compare_tag_s = 3'd1,
        writeback_s   = 3'd2,
        allocate_s    = 3'd3,
        pcs_write_s   = 3'd4,
        pcs_buf_s     = 3'd5
    } state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1023;
    localparam int unsigned CNT_W_DEFAULT          = 32;

    // States in which the controller is waiting on the memory interface.
    function automatic logic is_mem_wait(input state_t s);
        return (s == writeback_s) || (s == allocate_s);
    endfunction

endpackage

// File: rtl/pcs_sat_counter.sv
// Saturating up-counter used for the cache performance statistics.
// Holds at all-ones instead of wrapping; clear has priority over inc.
module pcs_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pcs_cache_control.sv
// Cache controller FSM with PCS full-line write path, memory watchdog and
// saturating hit/miss/writeback counters.
//
// state          | meaning
// ---------------+----------------------------------------------------------
// idle_s         | no transaction; accept PCS (priority) or CPU request
// compare_tag_s  | tag compare; choose hit / writeback / fill / PCS write
// writeback_s    | dirty victim going to memory, wait for mem_resp
// allocate_s     | line fill from memory, wait for mem_resp
// pcs_write_s    | PCS line written into the array (1 cycle)
// pcs_buf_s      | PCS write retires, pcs_done pulses (1 cycle)
module pcs_cache_control
    import cache_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_rmask,
    input  logic [31:0]      cpu_wmask,
    input  logic             write_pcs_cacheline,
    input  logic             valid_hit,
    input  logic             dirty,
    input  logic             mem_resp,
    output state_t           state,
    output logic             pcs_op,
    output logic             pcs_done,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count,
    output logic             mem_timeout
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    state_t            state_next;
    logic              pcs_op_next;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_cnt_next;
    logic              cpu_req;
    logic              hit_inc;
    logic              miss_inc;
    logic              wb_inc;

    assign cpu_req = cpu_rmask || (cpu_wmask != 32'd0);

    always_comb begin
        state_next  = state;
        pcs_op_next = pcs_op;
        case (state)
            idle_s: begin
                // A CPU request losing to PCS is not latched; the requester holds it.
                if (write_pcs_cacheline) begin
                    state_next  = compare_tag_s;
                    pcs_op_next = 1'b1;
                end else if (cpu_req) begin
                    state_next  = compare_tag_s;
                    pcs_op_next = 1'b0;
                end
            end
            compare_tag_s: begin
                if (valid_hit) begin
                    state_next = pcs_op ? pcs_write_s : idle_s;
                end else if (dirty) begin
                    state_next = writeback_s;
                end else if (pcs_op) begin
                    state_next = pcs_write_s;
                end else begin
                    state_next = allocate_s;
                end
            end
            writeback_s: begin
                if (mem_resp) begin
                    state_next = pcs_op ? pcs_write_s : allocate_s;
                end
            end
            allocate_s: begin
                if (mem_resp) begin
                    state_next = compare_tag_s;
                end
            end
            pcs_write_s: state_next = pcs_buf_s;
            pcs_buf_s:   state_next = idle_s;
            default:     state_next = idle_s;
        endcase
        if (state_next == idle_s) begin
            pcs_op_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= idle_s;
            pcs_op   <= 1'b0;
            pcs_done <= 1'b0;
        end else begin
            state    <= state_next;
            pcs_op   <= pcs_op_next;
            pcs_done <= (state_next == pcs_buf_s);
        end
    end

    // Watchdog restarts on every memory-wait entry, including writeback -> allocate.
    always_comb begin
        wd_cnt_next = wd_cnt;
        if (is_mem_wait(state_next) && (state_next != state)) begin
            wd_cnt_next = '0;
        end else if (is_mem_wait(state) && (wd_cnt != WD_MAX)) begin
            wd_cnt_next = wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_next;
            if (is_mem_wait(state) && (wd_cnt_next == WD_MAX)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    assign hit_inc  = (state == compare_tag_s) && valid_hit;
    assign miss_inc = (state == compare_tag_s) && !valid_hit;
    assign wb_inc   = (state == writeback_s) && mem_resp;

    pcs_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    pcs_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

    pcs_sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (wb_inc),
        .count (wb_count)
    );

endmodule

// File: tb/tb_pcs_cache_control.sv
// Directed bench for pcs_cache_control; a second narrow-counter instance on the
// same stimulus exercises counter saturation.
module tb_pcs_cache_control;
    import cache_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rmask;
    logic [31:0] cpu_wmask;
    logic        write_pcs_cacheline;
    logic        valid_hit;
    logic        dirty;
    logic        mem_resp;

    state_t      st;
    logic        pcs_op;
    logic        pcs_done;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] wb_count;
    logic        mem_timeout;

    state_t      st_s;
    logic        pcs_op_s;
    logic        pcs_done_s;
    logic [1:0]  hit_count_s;
    logic [1:0]  miss_count_s;
    logic [1:0]  wb_count_s;
    logic        mem_timeout_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pcs_cache_control dut (
        .clk                 (clk),
        .rst                 (rst),
        .cpu_rmask           (cpu_rmask),
        .cpu_wmask           (cpu_wmask),
        .write_pcs_cacheline (write_pcs_cacheline),
        .valid_hit           (valid_hit),
        .dirty               (dirty),
        .mem_resp            (mem_resp),
        .state               (st),
        .pcs_op              (pcs_op),
        .pcs_done            (pcs_done),
        .hit_count           (hit_count),
        .miss_count          (miss_count),
        .wb_count            (wb_count),
        .mem_timeout         (mem_timeout)
    );

    pcs_cache_control #(.TIMEOUT_CYCLES(4), .CNT_W(2)) dut_s (
        .clk                 (clk),
        .rst                 (rst),
        .cpu_rmask           (cpu_rmask),
        .cpu_wmask           (cpu_wmask),
        .write_pcs_cacheline (write_pcs_cacheline),
        .valid_hit           (valid_hit),
        .dirty               (dirty),
        .mem_resp            (mem_resp),
        .state               (st_s),
        .pcs_op              (pcs_op_s),
        .pcs_done            (pcs_done_s),
        .hit_count           (hit_count_s),
        .miss_count          (miss_count_s),
        .wb_count            (wb_count_s),
        .mem_timeout         (mem_timeout_s)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_rmask           = 1'b0;
        cpu_wmask           = 32'd0;
        write_pcs_cacheline = 1'b0;
        valid_hit           = 1'b0;
        dirty               = 1'b0;
        mem_resp            = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int h, input int m, input int w);
        check_val({tag, "_hit"},  64'(hit_count),  64'(h));
        check_val({tag, "_miss"}, 64'(miss_count), 64'(m));
        check_val({tag, "_wb"},   64'(wb_count),   64'(w));
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();

        // reset state
        check_val("rst_state", 64'(st), 64'(idle_s));
        check_val("rst_pcs_op", 64'(pcs_op), 64'd0);
        check_val("rst_pcs_done", 64'(pcs_done), 64'd0);
        check_val("rst_timeout", 64'(mem_timeout), 64'd0);
        check_counts("rst", 0, 0, 0);
        rst = 1'b0;

        // stray mem_resp in idle is ignored
        mem_resp = 1'b1;
        step();
        check_val("idle_resp_state", 64'(st), 64'(idle_s));
        check_counts("idle_resp", 0, 0, 0);
        mem_resp = 1'b0;

        // read hit
        cpu_rmask = 1'b1;
        valid_hit = 1'b1;
        step();
        check_val("rd_hit_cmp", 64'(st), 64'(compare_tag_s));
        check_val("rd_hit_pcs_op", 64'(pcs_op), 64'd0);
        cpu_rmask = 1'b0;
        step();
        check_val("rd_hit_idle", 64'(st), 64'(idle_s));
        check_counts("rd_hit", 1, 0, 0);

        // dirty write miss with 5-cycle memory latency on each leg
        do_reset();
        cpu_wmask = 32'hF;
        dirty     = 1'b1;
        step();
        check_val("wm_cmp", 64'(st), 64'(compare_tag_s));
        cpu_wmask = 32'd0;
        step();
        check_val("wm_wb", 64'(st), 64'(writeback_s));
        check_val("wm_miss", 64'(miss_count), 64'd1);
        repeat (4) step();
        check_val("wm_wb_hold", 64'(st), 64'(writeback_s));
        mem_resp = 1'b1;
        step();
        check_val("wm_alloc", 64'(st), 64'(allocate_s));
        check_val("wm_wb_cnt", 64'(wb_count), 64'd1);
        mem_resp = 1'b0;
        dirty    = 1'b0;
        repeat (4) step();
        check_val("wm_alloc_hold", 64'(st), 64'(allocate_s));
        mem_resp = 1'b1;
        step();
        check_val("wm_refill_cmp", 64'(st), 64'(compare_tag_s));
        mem_resp  = 1'b0;
        valid_hit = 1'b1;
        step();
        check_val("wm_idle", 64'(st), 64'(idle_s));
        check_counts("wm", 1, 1, 1);
        valid_hit = 1'b0;

        // simultaneous PCS + CPU request, clean miss: PCS wins, no fill
        do_reset();
        write_pcs_cacheline = 1'b1;
        cpu_rmask           = 1'b1;
        step();
        check_val("pc_cmp", 64'(st), 64'(compare_tag_s));
        check_val("pc_pcs_op", 64'(pcs_op), 64'd1);
        write_pcs_cacheline = 1'b0;
        cpu_rmask           = 1'b0;
        step();
        check_val("pc_write", 64'(st), 64'(pcs_write_s));
        check_val("pc_done_early", 64'(pcs_done), 64'd0);
        check_val("pc_miss", 64'(miss_count), 64'd1);
        step();
        check_val("pc_buf", 64'(st), 64'(pcs_buf_s));
        check_val("pc_done", 64'(pcs_done), 64'd1);
        step();
        check_val("pc_idle", 64'(st), 64'(idle_s));
        check_val("pc_done_late", 64'(pcs_done), 64'd0);
        check_val("pc_op_clr", 64'(pcs_op), 64'd0);
        check_counts("pc", 0, 1, 0);

        // PCS dirty miss: writeback then straight to pcs_write
        do_reset();
        write_pcs_cacheline = 1'b1;
        dirty               = 1'b1;
        step();
        write_pcs_cacheline = 1'b0;
        step();
        check_val("pd_wb", 64'(st), 64'(writeback_s));
        mem_resp = 1'b1;
        step();
        check_val("pd_write", 64'(st), 64'(pcs_write_s));
        mem_resp = 1'b0;
        step();
        check_val("pd_buf", 64'(st), 64'(pcs_buf_s));
        check_val("pd_done", 64'(pcs_done), 64'd1);
        step();
        check_val("pd_idle", 64'(st), 64'(idle_s));
        check_counts("pd", 0, 1, 1);
        dirty = 1'b0;

        // PCS hit goes to pcs_write without any miss
        do_reset();
        write_pcs_cacheline = 1'b1;
        valid_hit           = 1'b1;
        step();
        write_pcs_cacheline = 1'b0;
        step();
        check_val("ph_write", 64'(st), 64'(pcs_write_s));
        check_counts("ph", 1, 0, 0);
        valid_hit = 1'b0;
        step();
        step();

        // watchdog: 1023 cycles in allocate without mem_resp
        do_reset();
        cpu_rmask = 1'b1;
        step();
        cpu_rmask = 1'b0;
        step();
        check_val("wd_alloc", 64'(st), 64'(allocate_s));
        repeat (1022) step();
        check_val("wd_not_yet", 64'(mem_timeout), 64'd0);
        step();
        check_val("wd_set", 64'(mem_timeout), 64'd1);
        check_val("wd_still_alloc", 64'(st), 64'(allocate_s));
        mem_resp = 1'b1;
        step();
        mem_resp  = 1'b0;
        valid_hit = 1'b1;
        step();
        check_val("wd_idle", 64'(st), 64'(idle_s));
        check_val("wd_sticky", 64'(mem_timeout), 64'd1);
        valid_hit = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("wd_rst_clr", 64'(mem_timeout), 64'd0);

        // reset mid-writeback with mem_resp on the same edge
        do_reset();
        write_pcs_cacheline = 1'b1;
        dirty               = 1'b1;
        step();
        write_pcs_cacheline = 1'b0;
        step();
        check_val("rw_wb", 64'(st), 64'(writeback_s));
        check_val("rw_pcs_op_set", 64'(pcs_op), 64'd1);
        rst      = 1'b1;
        mem_resp = 1'b1;
        step();
        check_val("rw_idle", 64'(st), 64'(idle_s));
        check_val("rw_pcs_op", 64'(pcs_op), 64'd0);
        check_counts("rw", 0, 0, 0);
        rst = 1'b0;
        step();
        check_val("rw_late_resp", 64'(st), 64'(idle_s));
        check_val("rw_late_wb", 64'(wb_count), 64'd0);
        clear_inputs();

        // saturation: five hits on a 2-bit counter stick at 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cpu_rmask = 1'b1;
            valid_hit = 1'b1;
            step();
            cpu_rmask = 1'b0;
            step();
        end
        valid_hit = 1'b0;
        check_val("sat_hit_narrow", 64'(hit_count_s), 64'd3);
        check_val("sat_hit_wide", 64'(hit_count), 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pcs_cache_control.md
PCS_CACHE_CONTROL -- requirements
Module: pcs_cache_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: memory-response watchdog limit in cycles.
REQ-002 SHALL have parameter CNT_W, default 32: width of each performance counter.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port cpu_rmask, input, 1: CPU read request.
REQ-006 SHALL have port cpu_wmask, input, 32: CPU write byte mask; nonzero means write request.
REQ-007 SHALL have port write_pcs_cacheline, input, 1: PCS full-line write request.
REQ-008 SHALL have port valid_hit, input, 1: tag-compare hit from the cache datapath.
REQ-009 SHALL have port dirty, input, 1: the victim way is dirty.
REQ-010 SHALL have port mem_resp, input, 1: memory transfer complete.
REQ-011 SHALL have port state, output, state_t: current state, driven to the cache datapath.
REQ-012 SHALL have port pcs_op, output, 1: the current transaction is a PCS write.
REQ-013 SHALL have port pcs_done, output, 1: one-cycle pulse when the PCS write retires.
REQ-014 SHALL have port hit_count, miss_count and wb_count, each output, CNT_W: performance counters.
REQ-015 SHALL have port mem_timeout, output, 1: sticky watchdog flag.

Function
REQ-016 SHALL implement the states idle_s, compare_tag_s, writeback_s, allocate_s, pcs_write_s and pcs_buf_s as one registered FSM.
REQ-017 In idle_s: write_pcs_cacheline -> compare_tag_s with pcs_op set; else (cpu_rmask or cpu_wmask != 0) -> compare_tag_s with pcs_op clear; else stay in idle_s.
REQ-018 If PCS and CPU requests arrive in the same cycle, PCS SHALL win; the CPU request is not latched and must be held by the requester.
REQ-019 pcs_op SHALL be captured only on the idle_s -> compare_tag_s transition and SHALL be cleared on entry to idle_s.
REQ-020 In compare_tag_s, exits SHALL be:
- valid_hit and !pcs_op -> idle_s
- valid_hit and pcs_op -> pcs_write_s
- !valid_hit and dirty -> writeback_s
- !valid_hit and !dirty and pcs_op -> pcs_write_s (no fill needed)
- !valid_hit and !dirty and !pcs_op -> allocate_s
REQ-021 writeback_s SHALL hold until mem_resp, then go to pcs_write_s if pcs_op, else to allocate_s.
REQ-022 allocate_s SHALL hold until mem_resp, then go to compare_tag_s.
REQ-023 pcs_write_s SHALL last exactly 1 cycle and go to pcs_buf_s.
REQ-024 pcs_buf_s SHALL last exactly 1 cycle, assert pcs_done for that cycle, and go to idle_s.
REQ-025 A mem_resp outside writeback_s or allocate_s SHALL be ignored.
REQ-026 hit_count SHALL increment once per compare_tag_s cycle with valid_hit.
REQ-027 miss_count SHALL increment on each compare_tag_s exit to writeback_s, allocate_s, or pcs_write_s with !valid_hit.
REQ-028 wb_count SHALL increment on each writeback_s exit.
REQ-029 All counters SHALL saturate at all-ones and never wrap.
REQ-030 A refill that returns to compare_tag_s hits there and counts as a hit; this hit is counted in addition to the miss.
REQ-031 The watchdog counter SHALL clear on entry to writeback_s or allocate_s and increment each cycle waiting there.
REQ-032 When the watchdog counter reaches TIMEOUT_CYCLES, mem_timeout SHALL be set and held until reset; the FSM keeps waiting.

Reset
REQ-033 On rst the FSM SHALL go to idle_s, and pcs_op, pcs_done, mem_timeout, the watchdog counter and all performance counters SHALL be cleared.
REQ-034 rst SHALL take priority over every transition, including mid-writeback or mid-allocate; in-flight memory responses arriving after reset are ignored per REQ-025.

Structure
REQ-035 state_t SHALL be an enum in package cache_types, shared with the cache datapath; TIMEOUT_CYCLES's default SHALL be a constant in that package.
REQ-036 A sub-module pcs_sat_counter (CNT_W parameter, inc/clear inputs) SHALL be instantiated three times for the performance counters.

Verification
REQ-037 Read hit: cpu_rmask=1 in idle_s, valid_hit=1 -> states idle, compare, idle; hit_count=1, miss_count=0.
REQ-038 Dirty write miss: cpu_wmask=32'hF, valid_hit=0, dirty=1, mem_resp after 5 cycles in each of writeback and allocate -> states writeback, allocate, compare (hit), idle; wb_count=1, miss_count=1, hit_count=1.
REQ-039 Simultaneous PCS and CPU request in idle_s, miss, clean victim -> states compare, pcs_write, pcs_buf, idle; pcs_done high exactly 1 cycle; no allocate_s visited.
REQ-040 PCS dirty miss -> states writeback, pcs_write, pcs_buf, idle; wb_count=1.
REQ-041 Hold allocate_s without mem_resp for 1023 cycles -> mem_timeout=1 on the following cycle and stays set after later mem_resp; rst clears it.
REQ-042 Assert rst mid-writeback with mem_resp high on the same cycle -> next state idle_s, all counters 0, pcs_op 0.
